// File: rtl/prbs_gen.sv
// prbs_gen: Fibonacci-LFSR pseudo-random bit-sequence generator. It emits
// OUT_W sequence bits per word on a valid/ready stream, supports run-time
// seed loading with all-zero lock-up recovery, and flags the word that
// contains the first bit of each sequence period.
//
// Ports:
//   i_clk     clock
//   i_reset   synchronous active-high reset
//   i_enable  run request
//   i_load    one-cycle seed-load strobe (priority over all but reset)
//   i_seed    seed sampled while i_load=1
//   o_data    output word, bit 0 is the earliest sequence bit
//   o_valid   o_data holds a valid word
//   i_ready   consumer accepts the word
//   o_period  word contains the first bit of a period
//   o_lockup  one-cycle pulse: a zero seed was replaced by SEED
module prbs_gen #(
    parameter int unsigned           WIDTH = 9,
    parameter logic [WIDTH-1:0]      POLY  = 9'h110,
    parameter logic [WIDTH-1:0]      SEED  = 9'h025,
    parameter int unsigned           OUT_W = 1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_enable,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_seed,
    output logic [OUT_W-1:0] o_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_period,
    output logic             o_lockup
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state_q, state_nxt;
    logic [WIDTH-1:0]   lfsr_q, lfsr_nxt;
    logic [WIDTH-1:0]   start_q, start_nxt;
    logic [OUT_W-1:0]   data_nxt;
    logic               valid_nxt;
    logic               period_nxt;
    logic               lockup_nxt;

    logic [WIDTH-1:0]   walk;
    logic [OUT_W-1:0]   gen_data;
    logic               gen_period;
    logic [WIDTH-1:0]   gen_next;
    logic [WIDTH-1:0]   seed_eff;
    logic               xfer;

    // Unrolled OUT_W LFSR steps: word bits, period hit and advanced state.
    always_comb begin
        walk       = lfsr_q;
        gen_data   = '0;
        gen_period = 1'b0;
        for (int unsigned i = 0; i < OUT_W; i++) begin
            gen_data[i] = walk[WIDTH-1];
            if (walk == start_q) begin
                gen_period = 1'b1;
            end
            walk = {walk[WIDTH-2:0], ^(walk & POLY)};
        end
        gen_next = walk;
    end

    // A zero seed would lock the LFSR, so it is replaced by SEED.
    assign seed_eff = (i_seed == '0) ? SEED : i_seed;
    assign xfer     = o_valid & i_ready;

    // Next-state and next-output logic.
    always_comb begin
        state_nxt  = state_q;
        lfsr_nxt   = lfsr_q;
        start_nxt  = start_q;
        data_nxt   = o_data;
        valid_nxt  = o_valid;
        period_nxt = o_period;
        lockup_nxt = 1'b0;

        if (i_load) begin
            lfsr_nxt   = seed_eff;
            start_nxt  = seed_eff;
            lockup_nxt = (i_seed == '0);
            valid_nxt  = 1'b0;
            state_nxt  = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_enable) begin
                        data_nxt   = gen_data;
                        period_nxt = gen_period;
                        lfsr_nxt   = gen_next;
                        valid_nxt  = 1'b1;
                        state_nxt  = RUN;
                    end
                end
                RUN: begin
                    // Without a transfer the offered word is held.
                    if (xfer) begin
                        if (i_enable) begin
                            data_nxt   = gen_data;
                            period_nxt = gen_period;
                            lfsr_nxt   = gen_next;
                        end else begin
                            valid_nxt  = 1'b0;
                            state_nxt  = IDLE;
                        end
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    valid_nxt = 1'b0;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q  <= IDLE;
            lfsr_q   <= SEED;
            start_q  <= SEED;
            o_data   <= '0;
            o_valid  <= 1'b0;
            o_period <= 1'b0;
            o_lockup <= 1'b0;
        end else begin
            state_q  <= state_nxt;
            lfsr_q   <= lfsr_nxt;
            start_q  <= start_nxt;
            o_data   <= data_nxt;
            o_valid  <= valid_nxt;
            o_period <= period_nxt;
            o_lockup <= lockup_nxt;
        end
    end

endmodule

// File: tb/tb_prbs_gen.sv
// Testbench for prbs_gen: a 1-bit and an 8-bit instance share the same
// stimulus. A reference model built from the sequence definition (a bit
// list indexed by position) predicts every output; table rows and
// hand-written sequences pin the documented corner cases.
module tb_prbs_gen;

    localparam logic [8:0] P = 9'h110;
    localparam logic [8:0] S = 9'h025;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst  = 1'b1;
    logic       en   = 1'b0;
    logic       ld   = 1'b0;
    logic       rdy  = 1'b0;
    logic [8:0] seed = '0;

    logic [0:0] d1;
    logic [7:0] d8;
    logic       v1, v8, p1, p8, l1, l8;

    prbs_gen #(.WIDTH(9), .POLY(P), .SEED(S), .OUT_W(1)) u_w1 (
        .i_clk(clk), .i_reset(rst), .i_enable(en), .i_load(ld), .i_seed(seed),
        .o_data(d1), .o_valid(v1), .i_ready(rdy), .o_period(p1), .o_lockup(l1)
    );

    prbs_gen #(.WIDTH(9), .POLY(P), .SEED(S), .OUT_W(8)) u_w8 (
        .i_clk(clk), .i_reset(rst), .i_enable(en), .i_load(ld), .i_seed(seed),
        .o_data(d8), .o_valid(v8), .i_ready(rdy), .o_period(p8), .o_lockup(l8)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: the sequence as a list of bits from the start state.
    logic        seq [0:511];
    int          seq_len;
    logic        mv   [2];
    int          mpos [2];
    logic [63:0] md   [2];
    logic        mp   [2];
    logic        ml;

    function automatic int word_w(input int k);
        return (k == 0) ? 1 : 8;
    endfunction

    task automatic build_seq(input logic [8:0] sd);
        int s;
        int n;
        s = int'(sd);
        n = 0;
        do begin
            seq[n] = s[8];
            s = ((s << 1) | ($countones(s & int'(P)) & 1)) & 511;
            n++;
        end while (s != int'(sd) && n < 512);
        seq_len = n;
    endtask

    task automatic model_word(input int k);
        int idx;
        md[k] = '0;
        mp[k] = 1'b0;
        for (int i = 0; i < word_w(k); i++) begin
            idx = (mpos[k] + i) % seq_len;
            md[k][i] = seq[idx];
            if (idx == 0) mp[k] = 1'b1;
        end
        mpos[k] = (mpos[k] + word_w(k)) % seq_len;
    endtask

    task automatic model_edge();
        if (rst) begin
            build_seq(S);
            ml = 1'b0;
            for (int k = 0; k < 2; k++) begin
                mv[k] = 1'b0; md[k] = '0; mp[k] = 1'b0; mpos[k] = 0;
            end
        end else if (ld) begin
            build_seq((seed == 9'd0) ? S : seed);
            ml = (seed == 9'd0);
            for (int k = 0; k < 2; k++) begin
                mv[k] = 1'b0; mpos[k] = 0;
            end
        end else begin
            ml = 1'b0;
            for (int k = 0; k < 2; k++) begin
                if (en && (!mv[k] || rdy)) begin
                    model_word(k);
                    mv[k] = 1'b1;
                end else if (mv[k] && rdy) begin
                    mv[k] = 1'b0;
                end
            end
        end
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", nm, $time, act, exp);
        end
    endtask

    task automatic model_check();
        chk("w1 valid", 64'(v1), 64'(mv[0]));
        chk("w8 valid", 64'(v8), 64'(mv[1]));
        chk("w1 lockup", 64'(l1), 64'(ml));
        chk("w8 lockup", 64'(l8), 64'(ml));
        if (mv[0]) begin
            chk("w1 data", 64'(d1), md[0]);
            chk("w1 period", 64'(p1), 64'(mp[0]));
        end
        if (mv[1]) begin
            chk("w8 data", 64'(d8), md[1]);
            chk("w8 period", 64'(p8), 64'(mp[1]));
        end
    endtask

    // One clock: model follows the inputs sampled at the edge, check 1ns later.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        model_check();
    endtask

    typedef struct {
        logic       rst, en, rdy, ld;
        logic [8:0] seed;
        logic       ev, cd;
        logic [7:0] ed;
        logic       ep, el;
    } vec_t;

    vec_t       tbl [17];
    logic [8:0] first9;
    logic       exp_bit;

    initial begin
        // rst en rdy ld seed | valid chk data period lockup  (8-bit instance)
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 9'h000, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 9'h000, 1'b1, 1'b1, 8'h48, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 9'h000, 1'b1, 1'b1, 8'h48, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 9'h000, 1'b1, 1'b1, 8'h48, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 9'h000, 1'b1, 1'b1, 8'h48, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 9'h000, 1'b1, 1'b1, 8'h48, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 9'h000, 1'b1, 1'b1, 8'h48, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 9'h000, 1'b1, 1'b1, 8'hB9, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 9'h000, 1'b1, 1'b1, 8'hB9, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 9'h000, 1'b1, 1'b1, 8'hB9, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 9'h000, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 9'h000, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 9'h000, 1'b1, 1'b1, 8'hC5, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 1'b1, 1'b1, 1'b1, 9'h000, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};
        tbl[14] = '{1'b0, 1'b1, 1'b1, 1'b0, 9'h000, 1'b1, 1'b1, 8'h48, 1'b1, 1'b0};
        tbl[15] = '{1'b0, 1'b1, 1'b1, 1'b0, 9'h000, 1'b1, 1'b1, 8'hB9, 1'b0, 1'b0};
        tbl[16] = '{1'b0, 1'b0, 1'b1, 1'b0, 9'h000, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};

        // Directed table on the 8-bit instance: startup, stall, drop, zero-seed load.
        for (int r = 0; r < 17; r++) begin
            rst = tbl[r].rst; en = tbl[r].en; rdy = tbl[r].rdy;
            ld = tbl[r].ld; seed = tbl[r].seed;
            step();
            chk("tbl valid", 64'(v8), 64'(tbl[r].ev));
            chk("tbl lockup", 64'(l8), 64'(tbl[r].el));
            if (tbl[r].cd) begin
                chk("tbl data", 64'(d8), 64'(tbl[r].ed));
                chk("tbl period", 64'(p8), 64'(tbl[r].ep));
            end
        end

        // OUT_W=1 from reset: first nine bits and period markers at words 0 and 511.
        first9 = 9'h148;
        rst = 1'b1; en = 1'b0; rdy = 1'b0; ld = 1'b0;
        step();
        rst = 1'b0; en = 1'b1; rdy = 1'b1;
        for (int k = 0; k < 1022; k++) begin
            step();
            chk("seq1 valid", 64'(v1), 64'd1);
            if (k < 9) begin
                exp_bit = first9[k];
                chk("seq1 bit", 64'(d1), 64'(exp_bit));
            end
            chk("seq1 period", 64'(p1), 64'((k == 0) || (k == 511)));
        end

        // Load 0x1FF: nine ones first, period markers at words 0 and 511.
        ld = 1'b1; seed = 9'h1FF;
        step();
        chk("ld1ff valid", 64'(v1), 64'd0);
        chk("ld1ff lockup", 64'(l1), 64'd0);
        ld = 1'b0;
        for (int k = 0; k < 1022; k++) begin
            step();
            if (k < 9) chk("ld1ff bit", 64'(d1), 64'd1);
            chk("ld1ff period", 64'(p1), 64'((k == 0) || (k == 511)));
        end

        // Randomized traffic against the reference model.
        for (int c = 0; c < 4000; c++) begin
            rst  = ($urandom_range(0, 299) == 0);
            en   = ($urandom_range(0, 3) != 0);
            rdy  = ($urandom_range(0, 2) != 0);
            ld   = ($urandom_range(0, 39) == 0);
            seed = ($urandom_range(0, 3) == 0) ? 9'd0 : 9'($urandom);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
